// File: rtl/morse_pkg.sv
// Shared definitions for the Morse symbol path.
// Symbol codes seen on the keyer interface, the bit value stored for a dash,
// and a helper that sizes length fields for a given maximum symbol count.
package morse_pkg;

  localparam logic [1:0] SYM_NONE = 2'b00;
  localparam logic [1:0] SYM_DOT  = 2'b01;
  localparam logic [1:0] SYM_DASH = 2'b10;
  localparam logic [1:0] SYM_EOL  = 2'b11;

  localparam logic DASH_BIT = 1'b1;

  // Bits needed to hold any count from 0 to max inclusive.
  function automatic int unsigned len_w(input int unsigned max);
    return $clog2(max + 1);
  endfunction

endpackage

// File: rtl/morse_letter_slot.sv
// One-deep valid/ready holding register for a committed letter.
// Ports:
//   clk, reset (async, active-low), clear (sync flush)
//   load, load_data : write payload; caller only loads when the slot is free
//                     (empty, or being accepted this cycle)
//   ready           : downstream accepts when valid && ready
//   valid, data     : slot contents, driven straight from registers
//   accept          : handshake completing this cycle
//   full            : slot currently occupied
module morse_letter_slot
  import morse_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         accept,
  output logic         full
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      // A load in the same cycle as an accept keeps valid high.
      valid <= 1'b1;
      data  <= load_data;
    end else if (accept) begin
      valid <= 1'b0;
    end
  end

  always_comb begin
    accept = valid && ready;
    full   = valid;
  end

endmodule

// File: rtl/morse_symbol_buffer.sv
// Morse symbol buffer: accumulates dot/dash symbols into a letter register of
// MAX_SYMBOLS bits (latest symbol at bit 0, dash=1) and, on end-of-letter,
// commits the letter, its length and an overflow flag into a one-deep output
// slot handshaked with the letter decoder.
// Ports:
//   clk, reset (async, active-low), clear (sync flush, highest priority)
//   sym_valid, sym_code           : symbol strobe from the keyer
//   letter_valid, letter_ready    : output handshake
//   letter_bits, letter_len,
//   letter_ovf                    : committed letter contents
//   drop_pulse, drop_sticky       : letter lost because the slot was full
//   busy                          : accumulator holds a partial letter
module morse_symbol_buffer
  import morse_pkg::*;
#(
  parameter int unsigned MAX_SYMBOLS = 10
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                clear,
  input  logic                                sym_valid,
  input  logic [1:0]                          sym_code,
  output logic                                letter_valid,
  input  logic                                letter_ready,
  output logic [MAX_SYMBOLS-1:0]              letter_bits,
  output logic [len_w(MAX_SYMBOLS)-1:0]       letter_len,
  output logic                                letter_ovf,
  output logic                                drop_pulse,
  output logic                                drop_sticky,
  output logic                                busy
);

  localparam int unsigned LEN_W = len_w(MAX_SYMBOLS);
  localparam int unsigned PAY_W = MAX_SYMBOLS + LEN_W + 1;
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_SYMBOLS);

  generate
    if (MAX_SYMBOLS < 2) begin : g_bad_param
      $error("morse_symbol_buffer: MAX_SYMBOLS must be at least 2");
    end
  endgenerate

  logic [MAX_SYMBOLS-1:0] acc;
  logic [LEN_W-1:0]       acc_len;
  logic                   acc_ovf;

  logic                   is_sym;
  logic                   is_eol;
  logic                   sym_bit;
  logic                   commit;
  logic                   slot_free;
  logic                   slot_load;
  logic                   drop;
  logic                   slot_accept;
  logic                   slot_full;
  logic [PAY_W-1:0]       slot_data;

  always_comb begin
    is_sym    = sym_valid && (sym_code == SYM_DOT || sym_code == SYM_DASH);
    is_eol    = sym_valid && (sym_code == SYM_EOL);
    sym_bit   = (sym_code == SYM_DASH) ? DASH_BIT : ~DASH_BIT;
    // Empty letters are never committed.
    commit    = is_eol && (acc_len != '0 || acc_ovf);
    slot_free = !slot_full || letter_ready;
    slot_load = commit && slot_free && !clear;
    drop      = commit && !slot_free;
    busy      = (acc_len != '0) || acc_ovf;
  end

  // Accumulator: EOL checks first since sym and eol codes are exclusive.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc     <= '0;
      acc_len <= '0;
      acc_ovf <= 1'b0;
    end else if (clear) begin
      acc     <= '0;
      acc_len <= '0;
      acc_ovf <= 1'b0;
    end else if (commit) begin
      acc     <= '0;
      acc_len <= '0;
      acc_ovf <= 1'b0;
    end else if (is_sym) begin
      if (acc_len < LEN_MAX) begin
        acc     <= {acc[MAX_SYMBOLS-2:0], sym_bit};
        acc_len <= acc_len + 1'b1;
      end else begin
        acc_ovf <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_pulse  <= 1'b0;
      drop_sticky <= 1'b0;
    end else if (clear) begin
      drop_pulse  <= 1'b0;
      drop_sticky <= 1'b0;
    end else begin
      drop_pulse  <= drop;
      drop_sticky <= drop_sticky || drop;
    end
  end

  morse_letter_slot #(
    .W (PAY_W)
  ) u_slot (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .load      (slot_load),
    .load_data ({acc, acc_len, acc_ovf}),
    .ready     (letter_ready),
    .valid     (letter_valid),
    .data      (slot_data),
    .accept    (slot_accept),
    .full      (slot_full)
  );

  always_comb begin
    {letter_bits, letter_len, letter_ovf} = slot_data;
  end

endmodule
